ahb_lite_master: RTL and testbench

AHB-Lite initiator that turns simple local read/write commands into pipelined AHB-Lite transfers toward the word-addressed slave memory on the same HCLK domain. Each command is a single transfer or an incrementing word burst of up to 16 beats. The block overlaps each address phase with the previous beat's data phase and honours HREADY wait states. Read data and completion are returned on a local strobe interface.

---
 rtl/ahb_lite_master.sv | 176 +++++++++++++++++
 tb/tb_ahb_lite_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
//
// AHB-Lite initiator that turns local read/write commands (one transfer or an
// incrementing word burst of up to 16 beats) into pipelined AHB-Lite
// transfers. Each address phase overlaps the previous beat's data phase, and
// HREADY wait states freeze the whole pipeline.
//
// Ports
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_write            1 = write, 0 = read
//   cmd_addr             start byte address; the low two bits are dropped
//   cmd_len              beat count minus one
//   wdata / wdata_pop    current write word / word consumed this cycle
//   rdata / rdata_valid  captured read word / one-cycle strobe per read beat
//   done                 one-cycle pulse after the final data phase
//   HSEL, HWRITE, HTRANS, HADDR, HWDATA   AHB-Lite master outputs
//   HREADY, HRDATA       AHB-Lite slave responses
// ---------------------------------------------------------------------------
module ahb_lite_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              HSEL,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_PIPE = 2'b10,
    ST_LAST = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(4);

  state_t              state_q,       state_d;
  logic                write_q,       write_d;
  logic [ADDR_W-1:0]   haddr_q,       haddr_d;
  logic [3:0]          cnt_q,         cnt_d;        // beats still to issue after the current one
  logic [DATA_W-1:0]   hwdata_q,      hwdata_d;
  logic [DATA_W-1:0]   rdata_q,       rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                done_q,        done_d;
  logic                addr_phase_s;

  // Address phase is live in ADDR and PIPE; PIPE and LAST also carry a data phase.
  assign addr_phase_s = (state_q == ST_ADDR) || (state_q == ST_PIPE);

  assign cmd_ready   = (state_q == ST_IDLE);
  assign HSEL        = addr_phase_s;
  assign HWRITE      = write_q;
  assign HADDR       = haddr_q;
  assign HWDATA      = hwdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign wdata_pop   = write_q & addr_phase_s & HREADY;

  // Transfer type decode from the current state.
  always_comb begin
    HTRANS = 2'b00;
    case (state_q)
      ST_ADDR: HTRANS = 2'b10;
      ST_PIPE: HTRANS = 2'b11;
      default: HTRANS = 2'b00;
    endcase
  end

  // Next-state, address/counter update and data capture.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    haddr_d       = haddr_q;
    cnt_d         = cnt_q;
    hwdata_d      = hwdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_ADDR;
          write_d = cmd_write;
          haddr_d = {cmd_addr[ADDR_W-1:2], 2'b00};
          cnt_d   = cmd_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR, ST_PIPE: begin
        if (HREADY) begin
          // In PIPE the previous beat's read data phase completes on this edge.
          if ((state_q == ST_PIPE) && !write_q) begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
          end else begin
            rdata_valid_d = 1'b0;
          end
          // The word popped now becomes HWDATA for the data phase that follows.
          if (write_q) begin
            hwdata_d = wdata;
          end else begin
            hwdata_d = hwdata_q;
          end
          if (cnt_q == 4'd0) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_PIPE;
            haddr_d = haddr_q + ADDR_INC;  // wraps modulo 2^ADDR_W
            cnt_d   = cnt_q - 4'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LAST: begin
        if (HREADY) begin
          if (!write_q) begin
            rdata_d       = HRDATA;
            rdata_valid_d = 1'b1;
          end else begin
            rdata_valid_d = 1'b0;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LAST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      haddr_q       <= '0;
      cnt_q         <= 4'd0;
      hwdata_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      haddr_q       <= haddr_d;
      cnt_q         <= cnt_d;
      hwdata_q      <= hwdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_master
//
// Directed bench for ahb_lite_master. The bench plays the slave by driving
// HREADY/HRDATA directly and checks every output against hand-computed
// values one time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wdata;
  logic        wdata_pop;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        HSEL;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [11:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  // Wait-state write burst tables, index = cycles after command acceptance.
  logic        ws_hready [1:8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0]  ws_trans  [1:8] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
  logic [11:0] ws_addr   [1:6] = '{12'h100, 12'h104, 12'h108, 12'h108, 12'h108, 12'h10C};
  logic        ws_pop    [1:8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] ws_wd     [0:3] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'hD3D3_3333};
  logic [31:0] ws_hwdata [2:7] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hB1B1_1111,
                                   32'hB1B1_1111, 32'hC2C2_2222, 32'hD3D3_3333};
  logic        ws_done   [1:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  ahb_lite_master #(.ADDR_W(12), .DATA_W(32)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_pop   (wdata_pop),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .HSEL        (HSEL),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HADDR       (HADDR),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"},   {31'd0, cmd_ready},   32'd1);
    chk({tag, " HTRANS"},      {30'd0, HTRANS},      32'd0);
    chk({tag, " HSEL"},        {31'd0, HSEL},        32'd0);
    chk({tag, " HWRITE"},      {31'd0, HWRITE},      32'd0);
    chk({tag, " HADDR"},       {20'd0, HADDR},       32'd0);
    chk({tag, " HWDATA"},      HWDATA,               32'd0);
    chk({tag, " rdata"},       rdata,                32'd0);
    chk({tag, " rdata_valid"}, {31'd0, rdata_valid}, 32'd0);
    chk({tag, " wdata_pop"},   {31'd0, wdata_pop},   32'd0);
    chk({tag, " done"},        {31'd0, done},        32'd0);
  endtask

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 12'h000;
    cmd_len   = 4'd0;
    wdata     = 32'h0000_0000;
    HREADY    = 1'b1;
    HRDATA    = 32'h0000_0000;

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    HRESETn = 1'b1;
    tick();

    // Single write: misaligned address is forced to 0x010
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h013; cmd_len = 4'd0;
    wdata = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 1'b0;
    chk("wr1 c1 HTRANS",    {30'd0, HTRANS},    32'h2);
    chk("wr1 c1 HADDR",     {20'd0, HADDR},     32'h010);
    chk("wr1 c1 HSEL",      {31'd0, HSEL},      32'd1);
    chk("wr1 c1 HWRITE",    {31'd0, HWRITE},    32'd1);
    chk("wr1 c1 wdata_pop", {31'd0, wdata_pop}, 32'd1);
    chk("wr1 c1 cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    wdata = 32'h0000_0000;
    chk("wr1 c2 HTRANS",    {30'd0, HTRANS},    32'h0);
    chk("wr1 c2 HSEL",      {31'd0, HSEL},      32'd0);
    chk("wr1 c2 HWDATA",    HWDATA,             32'hDEAD_BEEF);
    chk("wr1 c2 wdata_pop", {31'd0, wdata_pop}, 32'd0);
    chk("wr1 c2 done",      {31'd0, done},      32'd0);
    tick();
    chk("wr1 c3 done",      {31'd0, done},      32'd1);
    chk("wr1 c3 cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("wr1 c3 rvalid",    {31'd0, rdata_valid}, 32'd0);

    // Single read: rdata, rdata_valid and done three cycles after acceptance
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    chk("rd1 done gap",     {31'd0, done},      32'd0);
    chk("rd1 c1 HTRANS",    {30'd0, HTRANS},    32'h2);
    chk("rd1 c1 HADDR",     {20'd0, HADDR},     32'h010);
    chk("rd1 c1 HWRITE",    {31'd0, HWRITE},    32'd0);
    chk("rd1 c1 wdata_pop", {31'd0, wdata_pop}, 32'd0);
    tick();
    HRDATA = 32'hDEAD_BEEF;
    chk("rd1 c2 rvalid",    {31'd0, rdata_valid}, 32'd0);
    tick();
    HRDATA = 32'h0000_0000;
    chk("rd1 c3 rdata",     rdata,                32'hDEAD_BEEF);
    chk("rd1 c3 rvalid",    {31'd0, rdata_valid}, 32'd1);
    chk("rd1 c3 done",      {31'd0, done},        32'd1);
    tick();
    chk("rd1 c4 rvalid",    {31'd0, rdata_valid}, 32'd0);
    chk("rd1 c4 done",      {31'd0, done},        32'd0);

    // 4-beat read burst at 0x020; beat k returns 0x5000_0000 + k
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) begin
        chk($sformatf("rd4 c%0d HTRANS", c), {30'd0, HTRANS}, (c == 1) ? 32'h2 : 32'h3);
        chk($sformatf("rd4 c%0d HADDR", c),  {20'd0, HADDR},  32'h020 + 32'(4 * (c - 1)));
      end else begin
        chk($sformatf("rd4 c%0d HTRANS", c), {30'd0, HTRANS}, 32'h0);
      end
      if (c >= 3) begin
        chk($sformatf("rd4 c%0d rvalid", c), {31'd0, rdata_valid}, 32'd1);
        chk($sformatf("rd4 c%0d rdata", c),  rdata, 32'h5000_0000 + 32'(c - 3));
      end else begin
        chk($sformatf("rd4 c%0d rvalid", c), {31'd0, rdata_valid}, 32'd0);
      end
      chk($sformatf("rd4 c%0d done", c), {31'd0, done}, (c == 6) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 5) HRDATA = 32'h5000_0000 + 32'(c - 2);
      else                  HRDATA = 32'h0000_0000;
      tick();
    end
    chk("rd4 after done", {31'd0, done}, 32'd0);

    // 4-beat write burst with two wait states in beat 1's data phase
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h100; cmd_len = 4'd3;
    wdata = ws_wd[0];
    tick();
    cmd_valid = 1'b0;
    n_pops = 0;
    for (int c = 1; c <= 8; c++) begin
      HREADY = ws_hready[c];
      #1;
      chk($sformatf("ws c%0d HTRANS", c), {30'd0, HTRANS}, {30'd0, ws_trans[c]});
      if (c <= 6) chk($sformatf("ws c%0d HADDR", c), {20'd0, HADDR}, {20'd0, ws_addr[c]});
      if (c >= 2 && c <= 7) chk($sformatf("ws c%0d HWDATA", c), HWDATA, ws_hwdata[c]);
      chk($sformatf("ws c%0d wdata_pop", c), {31'd0, wdata_pop}, {31'd0, ws_pop[c]});
      chk($sformatf("ws c%0d done", c), {31'd0, done}, {31'd0, ws_done[c]});
      if (wdata_pop) n_pops++;
      tick();
      // Upstream advances its word after every expected pop.
      if (ws_pop[c] && n_pops <= 3) wdata = ws_wd[n_pops];
    end
    HREADY = 1'b1;
    chk("ws pop count", 32'(n_pops), 32'd4);
    chk("ws after done", {31'd0, done}, 32'd0);

    // Address wrap: 0xFF8, 0xFFC, 0x000
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'hFF8; cmd_len = 4'd2;
    tick();
    cmd_valid = 1'b0;
    chk("wrap c1 HADDR", {20'd0, HADDR}, 32'hFF8);
    tick();
    chk("wrap c2 HADDR", {20'd0, HADDR}, 32'hFFC);
    chk("wrap c2 HTRANS", {30'd0, HTRANS}, 32'h3);
    tick();
    chk("wrap c3 HADDR", {20'd0, HADDR}, 32'h000);
    chk("wrap c3 HTRANS", {30'd0, HTRANS}, 32'h3);
    tick();
    HRDATA = 32'h0000_0F00;
    chk("wrap c4 HTRANS", {30'd0, HTRANS}, 32'h0);
    tick();
    HRDATA = 32'h0000_0000;
    chk("wrap c5 done",  {31'd0, done},  32'd1);
    chk("wrap c5 rdata", rdata, 32'h0000_0F00);

    // Reset during beat 2 of an 8-beat read burst
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h200; cmd_len = 4'd7;
    tick();
    cmd_valid = 1'b0;
    HRDATA = 32'h7777_0000;
    tick();
    tick();
    chk("rst pre HADDR", {20'd0, HADDR}, 32'h208);
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("rst mid");
    tick();
    tick();
    HRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rst post%0d done", c),      {31'd0, done},      32'd0);
      chk($sformatf("rst post%0d cmd_ready", c), {31'd0, cmd_ready}, 32'd1);
      chk($sformatf("rst post%0d HTRANS", c),    {30'd0, HTRANS},    32'd0);
    end

    // Fresh single read after reset release
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    chk("post c1 HTRANS", {30'd0, HTRANS}, 32'h2);
    chk("post c1 HADDR",  {20'd0, HADDR},  32'h040);
    tick();
    HRDATA = 32'h1234_5678;
    tick();
    HRDATA = 32'h0000_0000;
    chk("post c3 rdata",  rdata,                32'h1234_5678);
    chk("post c3 rvalid", {31'd0, rdata_valid}, 32'd1);
    chk("post c3 done",   {31'd0, done},        32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
